// File: rtl/memset_engine_if.sv
// ----------------------------------------------------------------------------
// memset_engine_if
// Write-only memory bus between the memset engine and a memory controller.
//   memory_controller_address      : write address        (engine -> memory)
//   memory_controller_write_enable : write strobe         (engine -> memory)
//   memory_controller_in           : write data           (engine -> memory)
//   mem_ready                      : write accepted now   (memory -> engine)
// Modports: master = engine side, slave = memory side.
// ----------------------------------------------------------------------------
interface memset_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] memory_controller_address;
    logic                  memory_controller_write_enable;
    logic [DATA_WIDTH-1:0] memory_controller_in;
    logic                  mem_ready;

    modport master (
        output memory_controller_address,
        output memory_controller_write_enable,
        output memory_controller_in,
        input  mem_ready
    );

    modport slave (
        input  memory_controller_address,
        input  memory_controller_write_enable,
        input  memory_controller_in,
        output mem_ready
    );
endinterface

// File: rtl/memset_engine.sv
// ----------------------------------------------------------------------------
// memset_engine
// Fills n memory words starting at base address m with either a constant c
// (mode 0) or an incrementing pattern c, c+1, ... (mode 1). Address advances
// by STRIDE per word. The run can be cut short with abort.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : request a fill (only looked at while idle)
//   m, c, n, mode    : base address, fill value/seed, word count, pattern mode
//   abort            : end the fill early (only looked at while writing)
//   bus (master)     : write address/strobe/data out, mem_ready in
//   busy             : engine not idle
//   finish           : one-cycle completion pulse
//   aborted          : run ended by abort (valid with finish, held afterwards)
//   return_val       : base address of the completed run
//   words_written    : writes accepted during the last run
// ----------------------------------------------------------------------------
module memset_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int STRIDE     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] m,
    input  logic [DATA_WIDTH-1:0] c,
    input  logic [LEN_WIDTH-1:0]  n,
    input  logic                  mode,
    input  logic                  abort,
    memset_engine_if.master       bus,
    output logic                  busy,
    output logic                  finish,
    output logic                  aborted,
    output logic [ADDR_WIDTH-1:0] return_val,
    output logic [LEN_WIDTH-1:0]  words_written
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRIDE);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_mode;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_finish;
    logic                  r_aborted;
    logic [ADDR_WIDTH-1:0] r_return;
    logic [LEN_WIDTH-1:0]  r_words;

    wire w_last = (r_idx == r_len - LEN_WIDTH'(1));

    // Address and data are kept as running registers (base + i*STRIDE and
    // c + i) rather than recomputed from i, so no multiplier is needed and
    // the bus outputs come straight from flops. They are forced to zero
    // whenever the engine leaves WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_mode    <= 1'b0;
            r_idx     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
            r_aborted <= 1'b0;
            r_return  <= '0;
            r_words   <= '0;
        end else begin
            r_finish <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SETUP;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_base    <= m;
                    r_len     <= n;
                    r_mode    <= mode;
                    r_idx     <= '0;
                    r_words   <= '0;
                    r_aborted <= 1'b0;
                    r_return  <= '0;
                    if (n == '0) begin
                        // Empty fill: straight to completion, bus stays idle.
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                        r_return <= m;
                    end else begin
                        r_state <= S_WRITE;
                        r_we    <= 1'b1;
                        r_addr  <= m;
                        r_data  <= c;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ready) begin
                        r_words <= r_words + LEN_WIDTH'(1);
                        r_idx   <= r_idx + LEN_WIDTH'(1);
                        r_addr  <= r_addr + ADDR_STEP;
                        if (r_mode) begin
                            r_data <= r_data + DATA_WIDTH'(1);
                        end
                    end
                    // A write accepted in the abort cycle is still counted
                    // above; the zeroing below overrides the address/data step.
                    if (abort || (bus.mem_ready && w_last)) begin
                        r_state   <= S_DONE;
                        r_finish  <= 1'b1;
                        r_return  <= r_base;
                        r_aborted <= abort;
                        r_we      <= 1'b0;
                        r_addr    <= '0;
                        r_data    <= '0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memory_controller_address      = r_addr;
    assign bus.memory_controller_write_enable = r_we;
    assign bus.memory_controller_in           = r_data;

    assign busy          = r_busy;
    assign finish        = r_finish;
    assign aborted       = r_aborted;
    assign return_val    = r_return;
    assign words_written = r_words;

endmodule

// File: tb/tb_memset_engine.sv
module tb_memset_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [31:0] m = '0;
    logic [31:0] c = '0;
    logic [31:0] n = '0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic        mem_ready = 1'b1;
    logic        sel = 1'b0;

    logic        busy1, finish1, aborted1, busy2, finish2, aborted2;
    logic [31:0] ret1, ww1, ret2, ww2;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memset_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    memset_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
    assign bus1.mem_ready = mem_ready;
    assign bus2.mem_ready = mem_ready;

    memset_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(32), .STRIDE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .m(m), .c(c), .n(n), .mode(mode),
        .abort(abort), .bus(bus1.master), .busy(busy1), .finish(finish1),
        .aborted(aborted1), .return_val(ret1), .words_written(ww1)
    );

    memset_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(32), .STRIDE(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .m(m), .c(c), .n(n), .mode(mode),
        .abort(abort), .bus(bus2.master), .busy(busy2), .finish(finish2),
        .aborted(aborted2), .return_val(ret2), .words_written(ww2)
    );

    // Observed signals of the DUT currently under test
    wire        w_we   = sel ? bus2.memory_controller_write_enable : bus1.memory_controller_write_enable;
    wire [31:0] w_addr = sel ? bus2.memory_controller_address : bus1.memory_controller_address;
    wire [31:0] w_data = sel ? bus2.memory_controller_in : bus1.memory_controller_in;
    wire        w_fin  = sel ? finish2 : finish1;
    wire        w_ab   = sel ? aborted2 : aborted1;
    wire        w_busy = sel ? busy2 : busy1;
    wire [31:0] w_ret  = sel ? ret2 : ret1;
    wire [31:0] w_ww   = sel ? ww2 : ww1;

    typedef struct {
        bit          fin;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        bit          ab;
        logic [31:0] ret;
        logic [31:0] ww;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d, input int cy);
        exp_t e;
        e.fin = 1'b0; e.cyc = cy; e.addr = a; e.data = d; e.ab = 1'b0; e.ret = '0; e.ww = '0;
        q.push_back(e);
    endtask

    task automatic push_f(input int cy, input bit ab, input logic [31:0] r, input logic [31:0] w);
        exp_t e;
        e.fin = 1'b1; e.cyc = cy; e.addr = '0; e.data = '0; e.ab = ab; e.ret = r; e.ww = w;
        q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops expectations on accepted
    // writes and finish pulses, checks stall stability and idle-bus zeros.
    always @(negedge clk) begin
        if (w_we) begin
            if (q.size() == 0 || q[0].fin) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, none expected", w_addr, w_data, cyc);
            end else begin
                chk(mem_ready ? "write_addr" : "stall_addr", 64'(w_addr), 64'(q[0].addr));
                chk(mem_ready ? "write_data" : "stall_data", 64'(w_data), 64'(q[0].data));
                if (mem_ready) begin
                    chk("write_cycle", 64'(cyc), 64'(q[0].cyc));
                    $display("write addr=0x%0h data=0x%0h cycle=%0d", w_addr, w_data, cyc);
                    void'(q.pop_front());
                end
            end
        end else begin
            chk("idle_bus_zero", {w_addr, w_data}, 64'd0);
        end
        if (w_fin) begin
            if (q.size() == 0 || !q[0].fin) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_finish: finish at cycle %0d, none expected", cyc);
            end else begin
                chk("finish_cycle", 64'(cyc), 64'(q[0].cyc));
                chk("aborted", 64'(w_ab), 64'(q[0].ab));
                chk("return_val", 64'(w_ret), 64'(q[0].ret));
                chk("words_written", 64'(w_ww), 64'(q[0].ww));
                $display("finish cycle=%0d aborted=%0d return_val=0x%0h words_written=%0d", cyc, w_ab, w_ret, w_ww);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for the selected DUT; on return the SETUP edge has passed
    // and cyc == S+2 where S was cyc on entry. Inputs are then scrambled so
    // the run depends only on latched values.
    task automatic launch(input bit s, input logic [31:0] mm, input logic [31:0] cc,
                          input logic [31:0] nn, input bit md);
        sel = s;
        m = mm; c = cc; n = nn; mode = md;
        if (s) start2 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0; start2 = 1'b0;
        chk("busy_in_setup", 64'(w_busy), 64'd1);
        tick();
        m = 32'hDEAD_BEEF; c = 32'h1234_5678; n = 32'd7; mode = ~md;
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: %0d expected events never seen", q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int s;

        // Reset state
        repeat (3) tick();
        chk("reset_busy", {busy1, busy2}, 64'd0);
        chk("reset_finish", {finish1, finish2, aborted1, aborted2}, 64'd0);
        chk("reset_ret_ww", {ret1, ww1}, 64'd0);
        reset = 1'b0;
        tick();

        // Constant fill of 4 words
        s = cyc;
        for (int k = 0; k < 4; k++) push_w(32'h100 + k, 32'hAB, s + 2 + k);
        push_f(s + 6, 1'b0, 32'h100, 32'd4);
        launch(1'b0, 32'h100, 32'hAB, 32'd4, 1'b0);
        wait_empty();
        chk("busy_after_done", 64'(w_busy), 64'd0);
        repeat (3) tick();
        chk("hold_ret", 64'(ret1), 64'h100);
        chk("hold_ww", 64'(ww1), 64'd4);

        // Stride 4, incrementing pattern
        s = cyc;
        push_w(32'h10, 32'd5, s + 2);
        push_w(32'h14, 32'd6, s + 3);
        push_w(32'h18, 32'd7, s + 4);
        push_f(s + 5, 1'b0, 32'h10, 32'd3);
        launch(1'b1, 32'h10, 32'd5, 32'd3, 1'b1);
        wait_empty();
        chk("busy2_after_done", 64'(busy2), 64'd0);

        // Zero-length fill
        s = cyc;
        push_f(s + 2, 1'b0, 32'h55, 32'd0);
        launch(1'b0, 32'h55, 32'h99, 32'd0, 1'b0);
        wait_empty();

        // Stall on word 1 for 3 cycles, with data wrap through 0xFFFFFFFF
        s = cyc;
        push_w(32'h200, 32'hFFFF_FFFE, s + 2);
        push_w(32'h201, 32'hFFFF_FFFF, s + 6);
        push_w(32'h202, 32'h0000_0000, s + 7);
        push_w(32'h203, 32'h0000_0001, s + 8);
        push_f(s + 9, 1'b0, 32'h200, 32'd4);
        launch(1'b0, 32'h200, 32'hFFFF_FFFE, 32'd4, 1'b1);
        while (cyc < s + 10) begin
            tick();
            mem_ready = !(cyc >= s + 3 && cyc <= s + 5);
        end
        mem_ready = 1'b1;
        wait_empty();

        // Abort on word 2 (accepted), start pulsed mid-run must be ignored
        s = cyc;
        push_w(32'h300, 32'h7, s + 2);
        push_w(32'h301, 32'h7, s + 3);
        push_w(32'h302, 32'h7, s + 4);
        push_f(s + 5, 1'b1, 32'h300, 32'd3);
        launch(1'b0, 32'h300, 32'h7, 32'd8, 1'b0);
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_empty();
        chk("hold_aborted", 64'(aborted1), 64'd1);

        // Reset in the middle of WRITE: no finish, everything cleared
        s = cyc;
        push_w(32'h400, 32'h1, s + 2);
        push_w(32'h401, 32'h1, s + 3);
        push_w(32'h402, 32'h1, s + 4);
        launch(1'b0, 32'h400, 32'h1, 32'd8, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_run_busy", 64'(busy1), 64'd0);
        chk("rst_run_bus", {bus1.memory_controller_write_enable, bus1.memory_controller_address}, 64'd0);
        chk("rst_run_status", {finish1, aborted1, ww1[30:0]}, 64'd0);
        chk("rst_run_ret", 64'(ret1), 64'd0);
        wait_empty();
        repeat (5) tick();

        // Fresh run after the interrupted one
        s = cyc;
        push_w(32'h500, 32'd9, s + 2);
        push_w(32'h501, 32'd10, s + 3);
        push_f(s + 4, 1'b0, 32'h500, 32'd2);
        launch(1'b0, 32'h500, 32'd9, 32'd2, 1'b1);
        wait_empty();
        chk("aborted_cleared", 64'(aborted1), 64'd0);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memset_engine.md
MEMSET_ENGINE -- requirements
Module: memset_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write data width in bits.
REQ-003 SHALL have parameter LEN_WIDTH, default 32, width of the word count n.
REQ-004 SHALL have parameter STRIDE, default 1, address increment per word, range 1..2^ADDR_WIDTH-1.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request a fill; sampled only in IDLE.
REQ-008 SHALL have port m  input  ADDR_WIDTH  base address.
REQ-009 SHALL have port c  input  DATA_WIDTH  fill value or pattern seed.
REQ-010 SHALL have port n  input  LEN_WIDTH  number of words to write.
REQ-011 SHALL have port mode  input  1  0 = constant fill, 1 = incrementing pattern.
REQ-012 SHALL have port abort  input  1  stop the fill early; sampled only in WRITE.
REQ-013 SHALL have port mem_ready  input  1  memory accepts the current write this cycle.
REQ-014 SHALL have port memory_controller_address  output  ADDR_WIDTH  write address.
REQ-015 SHALL have port memory_controller_write_enable  output  1  write strobe.
REQ-016 SHALL have port memory_controller_in  output  DATA_WIDTH  write data.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port finish  output  1  one-cycle completion pulse.
REQ-019 SHALL have port aborted  output  1  high with finish when the run ended by abort.
REQ-020 SHALL have port return_val  output  ADDR_WIDTH  base address of the completed run.
REQ-021 SHALL have port words_written  output  LEN_WIDTH  number of writes accepted in the last run.

Function
REQ-022 SHALL implement a registered FSM with states IDLE, SETUP, WRITE and DONE.
REQ-023 IDLE->SETUP SHALL occur when start=1; while busy=1, start SHALL be ignored.
REQ-024 SETUP SHALL latch m, c, n and mode, and clear the index i and words_written; it SHALL last exactly 1 cycle.
REQ-025 SETUP SHALL go to DONE if the latched n==0 (no write issued); otherwise it SHALL go to WRITE.
REQ-026 In WRITE, memory_controller_write_enable SHALL be 1, memory_controller_address SHALL be m + i*STRIDE mod 2^ADDR_WIDTH, and memory_controller_in SHALL be c (mode 0) or c+i mod 2^DATA_WIDTH (mode 1).
REQ-027 Address, data and write enable SHALL hold stable while mem_ready=0 (stall); i SHALL advance only on a cycle with mem_ready=1.
REQ-028 A write SHALL count as accepted when WRITE and mem_ready=1; words_written SHALL increment on each accepted write.
REQ-029 WRITE->DONE SHALL occur on the accepted write where i==n-1.
REQ-030 abort=1 in WRITE SHALL move to DONE next cycle and set aborted.
  - A write accepted in that same cycle (mem_ready=1) SHALL still count.
REQ-031 Outside WRITE, memory_controller_write_enable SHALL be 0, and address and data SHALL be 0.
REQ-032 DONE SHALL assert finish=1 for exactly 1 cycle, drive return_val=latched m, then return to IDLE.
REQ-033 return_val, words_written and aborted SHALL hold their values until the next SETUP.
REQ-034 Best-case latency for n words with mem_ready held at 1 SHALL be n+2 cycles from the start-sampled edge to finish.
REQ-035 Index and address arithmetic SHALL wrap silently; no error flag SHALL be raised.

Reset
REQ-036 When reset=1 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0, including during a run.
  - An interrupted run SHALL produce no finish pulse.
REQ-037 Reset SHALL take priority over start and abort in the same cycle.

Verification
REQ-038 m=0x100, c=0xAB, n=4, mode=0, mem_ready=1 -> writes 0xAB to 0x100..0x103 in consecutive cycles; finish one cycle later; return_val=0x100; words_written=4.
REQ-039 STRIDE=4, m=0x10, c=5, n=3, mode=1 -> writes (0x10,5), (0x14,6), (0x18,7).
REQ-040 n=0 -> no write enable; finish 2 cycles after start; words_written=0.
REQ-041 n=4, mem_ready low for 3 cycles on word 1 -> word 1 address/data held stable; exactly 4 writes; finish at cycle 9.
REQ-042 n=8, abort asserted with mem_ready=1 on word 2 -> finish=1, aborted=1, words_written=3; start pulsed during the run is ignored.
REQ-043 reset asserted in WRITE -> next cycle all outputs 0 and state IDLE; no finish; a new start then runs normally.
